noc_axis_pkt_injector: RTL and testbench
========================================

// Module: noc_axis_pkt_injector
// PURPOSE
//  Upstream source stage for the 3-router NoC slice: buffers raw words from a producer and frames them
//  into AXI-Stream packets (TDEST, TLAST) that drive the NoC slave port (AXIS_S_* of the injecting router).
//  Store-and-forward, so a packet is never stalled mid-flight by an empty buffer.
//  This keeps wormhole channels from being held open while waiting on the producer.
// PARAMETERS
//  DATAW    32  payload/flit width (matches router TDATA_WIDTH)
//  DESTW    6   TDEST width (TDESTW+TIDW of the NoC)
//  FIFOD    64  buffer depth in words; power of two, >=2
//  PKTLENW  7   width of CFG_PKT_LEN; must hold FIFOD
//  CNTW     16  width of PKT_COUNT
// PORTS
//  CLK            in   1        single clock, all logic rising-edge
//  RST            in   1        synchronous, active-high reset
//  IN_VALID       in   1        producer word valid
//  IN_READY       out  1        buffer can accept (= !full)
//  IN_DATA        in   DATAW    producer word
//  IN_DEST        in   DESTW    destination tag stored with each word
//  CFG_PKT_LEN    in   PKTLENW  flits per packet; sampled at packet start
//  AXIS_M_TVALID  out  1        to router AXIS_S_TVALID
//  AXIS_M_TREADY  in   1        from router AXIS_S_TREADY
//  AXIS_M_TDATA   out  DATAW    flit payload
//  AXIS_M_TLAST   out  1        last flit of packet
//  AXIS_M_TDEST   out  DESTW    destination, constant for the whole packet
//  PKT_COUNT      out  CNTW     packets fully sent (TLAST handshakes), wraps
//  BUSY           out  1        high while in SEND
// BEHAVIOUR
//  Reset values:
//   - IN_READY=0 during RST, 1 in the first cycle after.
//   - TVALID=0, TLAST=0, TDATA=0, TDEST=0.
//   - PKT_COUNT=0, BUSY=0, FIFO empty, state IDLE.
//  Push: word+dest written on IN_VALID&IN_READY. No write-through when full, including a same-cycle pop.
//  Pop: on AXIS_M_TVALID&AXIS_M_TREADY only. Head is show-ahead, so TDATA is the FIFO head.
//  Packet length:
//   - eff_len = CFG_PKT_LEN clamped to [1, FIFOD]; 0 is treated as 1.
//   - eff_len is latched into len_q on the IDLE->SEND transition.
//   - CFG_PKT_LEN changes mid-packet have no effect on the current packet.
//  FSM:
//   - IDLE: when fifo_count (registered) >= eff_len, latch len_q, latch dest_q = head dest, flit_cnt=0,
//     go to SEND.
//   - SEND: TVALID=1; TLAST=(flit_cnt==len_q-1). On handshake flit_cnt++.
//   - SEND exit: on the TLAST handshake go to IDLE and PKT_COUNT++. At least one IDLE cycle between packets.
//  TDEST = dest_q for every flit of the packet; the per-word dests of flits 2..N are ignored.
//  AXIS rule: while TVALID=1 and TREADY=0, TDATA, TDEST and TLAST are held stable. TVALID never drops before
//   the handshake.
//  Latency: word accepted at edge t (len=1) gives TVALID high in cycle t+2. Peak throughput is 1 flit/cycle
//   within a packet.
//  Boundaries:
//   - Full: IN_READY=0.
//   - Empty: never occurs in SEND, guaranteed by the count>=len_q entry check.
//   - Pointers wrap modulo FIFOD. Count is log2(FIFOD)+1 bits.
//   - Simultaneous push and pop: count unchanged.
//  RST mid-packet: FIFO flushed and state->IDLE. TVALID=0 in the cycle after the reset edge. The partial packet
//   is dropped and is not counted.
// STRUCTURE
//  Shared noc_pkg: DATAW/DESTW defaults, typedef flit_t (logic [DATAW-1:0]), typedef dest_t,
//   enum inj_state_e {INJ_IDLE, INJ_SEND}.
//  One sub-module: noc_sync_fifo (show-ahead, DATAW+DESTW wide, FIFOD deep, exposes count/full/empty).
//  FSM, latches and counters stay in the top module.
// TESTING
//  1 Reset: hold RST 3 cycles with IN_VALID=1 -> IN_READY=0, TVALID=0, PKT_COUNT=0. IN_READY=1 in the
//    first cycle after.
//  2 LEN=4, push A0..A3 (dest=0x05), TREADY=1 -> TVALID rises 2 cycles after A3 accepted. Four consecutive
//    flits, TLAST only on A3, TDEST=0x05 throughout, PKT_COUNT=1.
//  3 LEN=4, push 3 words only -> TVALID stays 0 indefinitely. The 4th push starts the packet.
//  4 Backpressure: TREADY toggles 1,0,0,1... during a packet -> data/TLAST/TDEST stable while stalled.
//    No duplicated or lost flits.
//  5 Fill FIFOD=64 with TREADY=0 -> IN_READY=0 after the 64th push. A push attempt with the same-cycle pop
//    is refused. LEN=0 -> 1-flit packets with TLAST on every flit.
//  6 RST asserted after 2 of 4 flits sent -> TVALID=0 next cycle, FIFO empty, PKT_COUNT unchanged (0).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: default widths, flit/dest types and injector state encoding.
package noc_pkg;

  localparam int NOC_DATAW = 32;
  localparam int NOC_DESTW = 6;

  typedef logic [NOC_DATAW-1:0] flit_t;
  typedef logic [NOC_DESTW-1:0] dest_t;

  typedef enum logic [0:0] {
    INJ_IDLE = 1'b0,
    INJ_SEND = 1'b1
  } inj_state_e;

  // A zero length still means one flit; anything beyond the buffer depth could never start.
  function automatic int clamp_len(input int cfg, input int depth);
    if (cfg < 1) begin
      return 1;
    end else if (cfg > depth) begin
      return depth;
    end else begin
      return cfg;
    end
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is always visible on head_o.
module noc_sync_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses the write even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage array, written only; never reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/noc_axis_pkt_injector.sv
// Store-and-forward packet framer: buffers producer words and emits whole AXI-Stream packets
// with a per-packet TDEST, so a packet never stalls mid-flight on an empty buffer.
module noc_axis_pkt_injector
  import noc_pkg::*;
#(
  parameter int DATAW   = NOC_DATAW,
  parameter int DESTW   = NOC_DESTW,
  parameter int FIFOD   = 64,
  parameter int PKTLENW = 7,
  parameter int CNTW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATAW-1:0]   in_data_i,
  input  logic [DESTW-1:0]   in_dest_i,
  input  logic [PKTLENW-1:0] cfg_pkt_len_i,
  output logic               axis_m_tvalid_o,
  input  logic               axis_m_tready_i,
  output logic [DATAW-1:0]   axis_m_tdata_o,
  output logic               axis_m_tlast_o,
  output logic [DESTW-1:0]   axis_m_tdest_o,
  output logic [CNTW-1:0]    pkt_count_o,
  output logic               busy_o
);

  localparam int AW = $clog2(FIFOD);
  localparam int FW = DATAW + DESTW;

  logic [FW-1:0]      fifo_head;
  logic [AW:0]        fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [PKTLENW-1:0] eff_len;

  inj_state_e         state_q;
  logic [PKTLENW-1:0] len_q;
  logic [PKTLENW-1:0] flit_cnt_q;
  logic               tvalid_q;
  logic               tlast_q;
  logic [DESTW-1:0]   dest_q;
  logic [CNTW-1:0]    pkt_cnt_q;

  assign in_ready_o = ~fifo_full & ~rst_i;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = tvalid_q & axis_m_tready_i & ~fifo_empty;

  noc_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFOD)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({in_dest_i, in_data_i}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Effective packet length from the live configuration.
  always_comb begin
    eff_len = PKTLENW'(clamp_len(int'(cfg_pkt_len_i), FIFOD));
  end

  // Framing FSM; TVALID/TLAST/TDEST are registered and only change on handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INJ_IDLE;
      len_q      <= '0;
      flit_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      dest_q     <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      case (state_q)
        INJ_IDLE: begin
          if (int'(fifo_count) >= int'(eff_len)) begin
            state_q    <= INJ_SEND;
            len_q      <= eff_len;
            dest_q     <= fifo_head[FW-1:DATAW];
            flit_cnt_q <= '0;
            tvalid_q   <= 1'b1;
            tlast_q    <= (eff_len == PKTLENW'(1));
          end
        end
        INJ_SEND: begin
          if (axis_m_tready_i) begin
            if (tlast_q) begin
              state_q   <= INJ_IDLE;
              tvalid_q  <= 1'b0;
              tlast_q   <= 1'b0;
              pkt_cnt_q <= pkt_cnt_q + CNTW'(1);
            end else begin
              flit_cnt_q <= flit_cnt_q + PKTLENW'(1);
              tlast_q    <= ((flit_cnt_q + PKTLENW'(2)) == len_q);
            end
          end
        end
        default: begin
          state_q  <= INJ_IDLE;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign axis_m_tvalid_o = tvalid_q;
  assign axis_m_tlast_o  = tlast_q;
  assign axis_m_tdest_o  = dest_q;
  assign axis_m_tdata_o  = tvalid_q ? fifo_head[DATAW-1:0] : '0;
  assign pkt_count_o     = pkt_cnt_q;
  assign busy_o          = (state_q == INJ_SEND);

endmodule

// File: tb/tb_noc_axis_pkt_injector.sv
// Randomised scoreboard bench for noc_axis_pkt_injector: a word-stream model predicts every flit.
module tb_noc_axis_pkt_injector;

  typedef struct packed {
    logic        last;
    logic [5:0]  dest;
    logic [31:0] data;
  } flit_s;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [5:0]  in_dest;
  logic [6:0]  cfg_len;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [5:0]  tdest;
  logic [15:0] pkt_count;
  logic        busy;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    tready_mode = 3;
  int    pat_cnt = 0;
  int    model_len = 1;
  int    model_pos = 0;
  logic [5:0] model_pdest = '0;
  flit_s exp_q[$];
  int    exp_pkts = 0;

  noc_axis_pkt_injector dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .in_dest_i       (in_dest),
    .cfg_pkt_len_i   (cfg_len),
    .axis_m_tvalid_o (tvalid),
    .axis_m_tready_i (tready),
    .axis_m_tdata_o  (tdata),
    .axis_m_tlast_o  (tlast),
    .axis_m_tdest_o  (tdest),
    .pkt_count_o     (pkt_count),
    .busy_o          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Words are framed into packets of model_len in arrival order; the first word's dest tags the packet.
  function automatic void model_push(input logic [31:0] d, input logic [5:0] ds);
    flit_s f;
    if (model_pos == 0) model_pdest = ds;
    f.data = d;
    f.dest = model_pdest;
    f.last = (model_pos == model_len - 1);
    exp_q.push_back(f);
    model_pos = (model_pos + 1) % model_len;
  endfunction

  task automatic set_len(input int cfg);
    cfg_len   = 7'(cfg);
    model_len = (cfg < 1) ? 1 : ((cfg > 64) ? 64 : cfg);
    model_pos = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic push_until(input logic [31:0] d, input logic [5:0] ds);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_dest  = ds;
      #1;
      if (in_ready) begin
        model_push(d, ds);
        done = 1'b1;
      end
    end
    check("push_accept", 64'(done), 64'(1));
    @(posedge clk);
  endtask

  task automatic push_rand(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      push_until($urandom, 6'($urandom_range(0, 63)));
    end
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      if (exp_q.size() == 0 && !tvalid) done = 1'b1;
    end
    check(nm, 64'(done), 64'(1));
  endtask

  // TREADY pattern driver, updated away from the active edge.
  initial begin
    tready = 1'b0;
    forever begin
      @(negedge clk);
      case (tready_mode)
        0: tready = 1'b1;
        1: begin tready = (pat_cnt % 3 == 0); pat_cnt++; end
        2: tready = 1'($urandom_range(0, 1));
        3: tready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: compares every handshake with the scoreboard and checks hold-while-stalled.
  initial begin
    flit_s e;
    bit prev_stall;
    logic [31:0] p_data;
    logic [5:0]  p_dest;
    logic        p_last;
    prev_stall = 1'b0;
    p_data = '0; p_dest = '0; p_last = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", 64'(tvalid), 64'(1));
          check("stall_tdata", 64'(tdata), 64'(p_data));
          check("stall_tdest", 64'(tdest), 64'(p_dest));
          check("stall_tlast", 64'(tlast), 64'(p_last));
        end
        if (tvalid && tready) begin
          check("flit_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tdata", 64'(tdata), 64'(e.data));
            check("tdest", 64'(tdest), 64'(e.dest));
            check("tlast", 64'(tlast), 64'(e.last));
          end
        end
        prev_stall = tvalid && !tready;
        p_data = tdata;
        p_dest = tdest;
        p_last = tlast;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int k;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h0; in_dest = 6'h0; cfg_len = 7'd4;

    // Reset: IN_READY low while held, high in the first cycle after.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_tvalid", 64'(tvalid), 64'(0));
      check("rst_pkt_count", 64'(pkt_count), 64'(0));
    end
    check("rst_tdata", 64'(tdata), 64'(0));
    check("rst_tdest", 64'(tdest), 64'(0));
    check("rst_tlast", 64'(tlast), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Four-flit packet, latency and consecutive flits.
    set_len(4);
    tready_mode = 0;
    for (int i = 0; i < 4; i++) push_until(32'hA0 + 32'(i), 6'h05);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("lat_t1_tvalid", 64'(tvalid), 64'(0));
    @(negedge clk);
    #1;
    check("lat_t2_tvalid", 64'(tvalid), 64'(1));
    check("lat_t2_busy", 64'(busy), 64'(1));
    drain("drain_pkt4");
    exp_pkts += 1;
    check("pkt_count_t2", 64'(pkt_count), 64'(exp_pkts));

    // Short of a full packet: nothing leaves until the last word arrives.
    push_rand(3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (tvalid) seen = 1'b1;
    end
    check("partial_no_tvalid", 64'(seen), 64'(0));
    push_rand(1, 1'b0);
    drain("drain_partial");
    exp_pkts += 1;
    check("pkt_count_t3", 64'(pkt_count), 64'(exp_pkts));

    // Backpressure 1,0,0 pattern.
    set_len(5);
    tready_mode = 1;
    push_rand(10, 1'b1);
    drain("drain_bp");
    exp_pkts += 2;
    check("pkt_count_t4", 64'(pkt_count), 64'(exp_pkts));

    // Fill the buffer, then attempt a push in the same cycle as a pop.
    tready_mode = 3;
    set_len(64);
    push_rand(64, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_in_ready", 64'(in_ready), 64'(0));
    tready_mode = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_dest = 6'h3F;
    #1;
    check("full_push_refused", 64'(in_ready), 64'(0));
    check("full_pop_tvalid", 64'(tvalid), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ready_after_pop", 64'(in_ready), 64'(1));
    drain("drain_full");
    exp_pkts += 1;
    check("pkt_count_full", 64'(pkt_count), 64'(exp_pkts));

    // Oversized length clamps to the buffer depth.
    tready_mode = 2;
    set_len(100);
    push_rand(64, 1'b1);
    drain("drain_clamp");
    exp_pkts += 1;
    check("pkt_count_clamp", 64'(pkt_count), 64'(exp_pkts));

    // Zero length means single-flit packets.
    set_len(0);
    push_rand(6, 1'b1);
    drain("drain_len0");
    exp_pkts += 6;
    check("pkt_count_len0", 64'(pkt_count), 64'(exp_pkts));

    // Random lengths, backpressure and producer gaps.
    for (int r = 0; r < 6; r++) begin
      set_len($urandom_range(0, 9));
      k = $urandom_range(1, 4);
      push_rand(k * model_len, 1'b1);
      drain("drain_rand");
      exp_pkts += k;
      check("pkt_count_rand", 64'(pkt_count), 64'(exp_pkts));
    end

    // Reset after two of four flits: partial packet dropped and not counted.
    tready_mode = 3;
    set_len(4);
    push_rand(4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (tvalid) seen = 1'b1;
    end
    check("rst_mid_start", 64'(seen), 64'(1));
    tready_mode = 4;
    @(negedge clk);
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b1;
    @(negedge clk);
    tready = 1'b0;
    rst = 1'b1;
    check("rst_mid_sent2", 64'(exp_q.size()), 64'(2));
    exp_q.delete();
    model_pos = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_tvalid", 64'(tvalid), 64'(0));
    check("rst_mid_pkt_count", 64'(pkt_count), 64'(0));
    check("rst_mid_in_ready", 64'(in_ready), 64'(1));
    exp_pkts = 0;
    set_len(1);
    tready_mode = 0;
    push_until(32'h1234_5678, 6'h2A);
    drain("drain_after_rst");
    exp_pkts += 1;
    check("pkt_count_after_rst", 64'(pkt_count), 64'(exp_pkts));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
